uart_si_ctrl: RTL
=================

// Module: uart_si_ctrl
// PURPOSE
//  Simple-interface (SI) bus master that owns one uart_top_si instance. After reset it programs
//  the control register and the baud divisor, then loops: it polls status, drains RX bytes to a
//  valid/ready output, and serves TX bytes from REQ_N requesters in round-robin order.
//  It sits between the UART SI slave port and on-chip byte producers and consumers.
// PARAMETERS
//  REQ_N     2        number of TX requesters (1..8)
//  CR_INIT   8'hA3    control word {rx_lvl=2'b10, tx_lvl=2'b10, rx_full=0, tx_full=0, rec_en=1, tr_en=1}
//  BAUD_DIV  16'h200  divisor written to reg 0x8
// PORTS
//  clk        in   1        clock
//  rstn       in   1        synchronous reset, active low
//  addr       out  4        SI address (0x0 CR/status, 0x4 data, 0x8 baud)
//  re         out  1        SI read enable
//  we         out  1        SI write enable
//  wd         out  32       SI write data
//  rd         in   32       SI read data; valid in the cycle after re; read of 0x4 pops the RX FIFO
//  tx_valid   in   REQ_N    per-requester byte valid
//  tx_data    in   8*REQ_N  per-requester byte; requester i uses [8*i+7:8*i]
//  tx_ready   out  REQ_N    one-cycle accept pulse to the granted requester
//  rx_valid   out  1        received byte held for the consumer
//  rx_data    out  8        received byte
//  rx_ready   in   1        consumer accepts rx_data
//  cfg_done   out  1        high once both config writes have completed
// BEHAVIOUR
//  - Reset (rstn low at posedge): state=CFG_CR; addr/we/re/wd/tx_ready/rx_valid/rx_data/cfg_done=0;
//    rr_ptr=REQ_N-1; the RX hold register is cleared. An in-flight byte is dropped without a
//    tx_ready pulse.
//  - FSM, one cycle per state unless noted:
//    CFG_CR:   we=1, addr=0x0, wd=CR_INIT -> CFG_BAUD
//    CFG_BAUD: we=1, addr=0x8, wd=BAUD_DIV; cfg_done<=1 -> POLL
//    POLL:     re=1, addr=0x0 -> POLL_W
//    POLL_W:   capture rd[7:0] as status (bit3 = RX data available, bit2 = TX full)
//      - If bit3 and the hold register is empty -> RX_RD.
//      - Else if !bit2 and any tx_valid -> TX_WR.
//      - Else -> POLL.
//    RX_RD:    re=1, addr=0x4 -> RX_W
//    RX_W:     rx_data<=rd[7:0], rx_valid<=1 -> POLL
//    TX_WR:    we=1, addr=0x4, wd={24'h0, tx_data[g]}; tx_ready[g]=1; rr_ptr<=g -> POLL
//  - Priority: RX drain beats TX in the same POLL_W. TX is still served when RX is pending but
//    the hold register is full. This provides backpressure and avoids deadlock.
//  - Grant g: the first i with tx_valid[i] set, searched from rr_ptr+1 upward with wrap at REQ_N.
//    g is computed combinationally in TX_WR from the tx_valid and tx_data sampled in that cycle.
//    Requesters hold valid/data stable until tx_ready. If no valid remains in TX_WR, no write
//    occurs and the state returns to POLL.
//  - rx_valid clears on rx_valid&&rx_ready. RX_W and a consumer handshake never coincide,
//    because RX_RD requires the hold register to be empty.
//  - At most one SI strobe (re or we) is high in any cycle. The SI outputs are combinational
//    from the state; all other outputs are registered.
//  - Byte loop latency: POLL, POLL_W, TX_WR = 3 cycles minimum per TX byte; RX byte in 4 cycles.
// STRUCTURE
//  - uart_si_pkg:
//    - addr constants UART_CR=4'h0, UART_DR=4'h4, UART_DV=4'h8
//    - status bit indices ST_RXNE=3, ST_TXF=2
//    - typedef uart_cr (packed: rx_fifo_lvl[1:0], tx_fifo_lvl[1:0], rx_full, tx_full, rec_en, tr_en)
//    - FSM state enum
//  - Sub-module rr_arb (REQ_N): req, ptr in; one-hot grant and index out; purely combinational.
// TESTING (bench wires uart_top_si with uart_rx=uart_tx loopback)
//  1. Reset release -> exactly two writes: 0x0<-0xA3, then 0x8<-0x200; cfg_done=1 the cycle after.
//  2. Requester 0 sends "Hello World!\n" with rx_ready=1 -> 13 rx_valid pulses, same bytes in order.
//  3. Both requesters always valid (0x41.., 0x61..) -> tx_ready alternates 0,1,0,1; RX stream interleaves A a B b.
//  4. rx_ready=0 while 6 bytes are sent -> one byte held, rest stay in the UART FIFO; TX keeps going;
//     rx_ready=1 -> all 6 bytes delivered, none lost or duplicated.
//  5. rstn low for 3 cycles mid-TX -> outputs reset, rx_valid=0, config rewritten, traffic resumes.
//  6. Model status bit2=1 (TX full) -> no writes to 0x4 and tx_ready=0 until the bit clears.

Source files
------------

// File: rtl/uart_si_pkg.sv
// rtl/uart_si_pkg.sv - shared constants, register layout and FSM states for uart_si_ctrl
//
// Purpose: SI register map, status bit positions, control word layout and the
//          controller state encoding shared by the controller files.
// Ports:   none (package).
package uart_si_pkg;

  localparam logic [3:0] UART_CR = 4'h0;  // control (write) / status (read)
  localparam logic [3:0] UART_DR = 4'h4;  // data; a read pops the RX FIFO
  localparam logic [3:0] UART_DV = 4'h8;  // baud divisor

  localparam int ST_RXNE = 3;  // RX FIFO not empty
  localparam int ST_TXF  = 2;  // TX FIFO full

  typedef struct packed {
    logic [1:0] rx_fifo_lvl;
    logic [1:0] tx_fifo_lvl;
    logic       rx_full;
    logic       tx_full;
    logic       rec_en;
    logic       tr_en;
  } uart_cr;

  typedef enum logic [2:0] {
    CFG_CR,
    CFG_BAUD,
    POLL,
    POLL_W,
    RX_RD,
    RX_W,
    TX_WR
  } si_state_e;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter
//
// Purpose: picks the first set request searching upward from ptr+1 with wrap.
// Ports:   req  in  N   request vector
//          ptr  in  IW  index of the last granted requester
//          gnt  out N   one-hot grant (zero when no request)
//          idx  out IW  index of the granted requester
//          any  out 1   at least one request is set
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // k runs 1..N so the last granted requester is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_si_ctrl.sv
// rtl/uart_si_ctrl.sv - SI bus master that configures a UART and moves bytes through it
//
// Purpose: writes control and baud registers after reset, then polls status, drains
//          RX bytes into a one-entry hold register and serves TX requesters round-robin.
// Ports:   clk, rstn                  clock, synchronous active-low reset
//          addr, re, we, wd, rd       SI master port (rd valid the cycle after re)
//          tx_valid, tx_data, tx_ready  per-requester TX byte handshake
//          rx_valid, rx_data, rx_ready  received byte handshake
//          cfg_done                   configuration writes completed
module uart_si_ctrl
  import uart_si_pkg::*;
#(
  parameter int            REQ_N    = 2,
  parameter uart_cr        CR_INIT  = 8'hA3,
  parameter logic [15:0]   BAUD_DIV = 16'h200
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [3:0]         addr,
  output logic               re,
  output logic               we,
  output logic [31:0]        wd,
  input  logic [31:0]        rd,
  input  logic [REQ_N-1:0]   tx_valid,
  input  logic [8*REQ_N-1:0] tx_data,
  output logic [REQ_N-1:0]   tx_ready,
  output logic               rx_valid,
  output logic [7:0]         rx_data,
  input  logic               rx_ready,
  output logic               cfg_done
);

  localparam int IW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  si_state_e     state;
  logic [IW-1:0] rr_ptr;
  logic [REQ_N-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [7:0]    sel_byte;

  // Only the low byte of rd carries status or data.
  logic unused_rd;
  assign unused_rd = ^rd[31:8];

  rr_arb #(.N(REQ_N), .IW(IW)) u_arb (
    .req (tx_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < REQ_N; i++) begin
      if (gnt[i]) sel_byte = tx_data[8*i +: 8];
    end
  end

  // SI strobes decode from the state; they are held off while rstn is low so that
  // no register access happens during reset even though the state is CFG_CR.
  always_comb begin
    addr = 4'h0;
    re   = 1'b0;
    we   = 1'b0;
    wd   = 32'h0;
    if (rstn) begin
      case (state)
        CFG_CR: begin
          we   = 1'b1;
          addr = UART_CR;
          wd   = {24'h0, CR_INIT};
        end
        CFG_BAUD: begin
          we   = 1'b1;
          addr = UART_DV;
          wd   = {16'h0, BAUD_DIV};
        end
        POLL: begin
          re   = 1'b1;
          addr = UART_CR;
        end
        RX_RD: begin
          re   = 1'b1;
          addr = UART_DR;
        end
        TX_WR: begin
          if (gnt_any) begin
            we   = 1'b1;
            addr = UART_DR;
            wd   = {24'h0, sel_byte};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= CFG_CR;
      tx_ready <= '0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      cfg_done <= 1'b0;
      rr_ptr   <= IW'(REQ_N - 1);
    end else begin
      tx_ready <= '0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        CFG_CR:   state <= CFG_BAUD;
        CFG_BAUD: begin
          cfg_done <= 1'b1;
          state    <= POLL;
        end
        POLL:     state <= POLL_W;
        POLL_W: begin
          // RX wins only if the hold register can take the byte; otherwise TX
          // keeps flowing so a stalled consumer cannot block transmission.
          if (rd[ST_RXNE] && !rx_valid)       state <= RX_RD;
          else if (!rd[ST_TXF] && |tx_valid)  state <= TX_WR;
          else                                state <= POLL;
        end
        RX_RD:    state <= RX_W;
        RX_W: begin
          rx_data  <= rd[7:0];
          rx_valid <= 1'b1;
          state    <= POLL;
        end
        TX_WR: begin
          if (gnt_any) begin
            tx_ready <= gnt;
            rr_ptr   <= gnt_idx;
          end
          state <= POLL;
        end
        default:  state <= CFG_CR;
      endcase
    end
  end

endmodule
